// File: rtl/stage_mm_pkg.sv
// Shared constants for the memory-access stage: datapath widths and bus FSM encodings.
package stage_mm_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned MEM_ADDR_W = 32;

  typedef logic [1:0] mm_state_t;

  localparam mm_state_t MM_IDLE   = 2'd0;
  localparam mm_state_t MM_REQ    = 2'd1;
  localparam mm_state_t MM_WAIT_R = 2'd2;
  localparam mm_state_t MM_DONE   = 2'd3;

endpackage

// File: rtl/stage_mm_if.sv
// Per-core data-memory bus with req/gnt/rvalid handshake.
interface stage_mm_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mm_bus_if.sv
// Bus-side FSM of the MM stage: issues the request, holds it until granted, waits for
// read data and buffers a result that completes while the pipeline is stalled.
module mm_bus_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] store_data,
  stage_mm_if.master        bus,
  output logic              stall_req,
  output logic              cpl,
  output logic              cpl_load,
  output logic [DATA_W-1:0] cpl_data,
  output logic              skip
);

  import stage_mm_pkg::*;

  mm_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] buf_q;
  logic              buf_load_q;
  logic              skip_q;
  logic              op_valid;
  logic              fin;
  logic              fin_load;

  // An op drained from DONE is still sitting in EX for one cycle; don't issue it twice.
  assign op_valid = en && !flush && (mem_rd || mem_wr) && !skip_q;

  always_comb begin
    state_d       = state_q;
    bus.mem_req   = 1'b0;
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    stall_req     = 1'b0;
    fin           = 1'b0;
    fin_load      = 1'b0;
    case (state_q)
      MM_IDLE: begin
        // Reset gates the request so an abandoned transaction is dropped at once.
        bus.mem_req   = op_valid && rst_n;
        bus.mem_we    = mem_wr;
        bus.mem_addr  = alu_res[ADDR_W-1:0];
        bus.mem_wdata = store_data;
        stall_req     = op_valid && !(mem_wr && bus.mem_gnt);
        if (op_valid) begin
          if (!bus.mem_gnt)  state_d = MM_REQ;
          else if (mem_wr)   fin     = 1'b1;
          else               state_d = MM_WAIT_R;
        end
      end
      MM_REQ: begin
        bus.mem_req = 1'b1;
        stall_req   = !(we_q && bus.mem_gnt);
        if (bus.mem_gnt) begin
          if (we_q) fin     = 1'b1;
          else      state_d = MM_WAIT_R;
        end
      end
      MM_WAIT_R: begin
        stall_req = !bus.mem_rvalid;
        if (bus.mem_rvalid) begin
          fin      = 1'b1;
          fin_load = 1'b1;
        end
      end
      MM_DONE: begin
        stall_req = 1'b1;
        if (!stall) state_d = MM_IDLE;
      end
      default: state_d = MM_IDLE;
    endcase
    if (fin) state_d = stall ? MM_DONE : MM_IDLE;
  end

  assign cpl      = !stall && (fin || (state_q == MM_DONE));
  assign cpl_load = (state_q == MM_DONE) ? buf_load_q : fin_load;
  assign cpl_data = (state_q == MM_DONE) ? buf_q : bus.mem_rdata;
  assign skip     = skip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MM_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      buf_q      <= '0;
      buf_load_q <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == MM_IDLE) && op_valid) begin
        addr_q  <= alu_res[ADDR_W-1:0];
        we_q    <= mem_wr;
        wdata_q <= store_data;
      end
      if (fin && stall) begin
        buf_q      <= bus.mem_rdata;
        buf_load_q <= fin_load;
      end
      if ((state_q == MM_DONE) && !stall) skip_q <= 1'b1;
      else if (!stall)                    skip_q <= 1'b0;
    end
  end

endmodule

// File: rtl/stage_mm.sv
// MM pipeline stage: write-back/forwarding registers fed by ALU results or bus load data.
module stage_mm #(
  parameter int unsigned DATA_W     = stage_mm_pkg::DATA_W,
  parameter int unsigned ADDR_W     = stage_mm_pkg::MEM_ADDR_W,
  parameter int unsigned REG_ADDR_W = stage_mm_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  reg_wr,
  input  logic [REG_ADDR_W-1:0] reg_addr_rd,
  input  logic [DATA_W-1:0]     alu_res,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [DATA_W-1:0]     store_data,
  output logic                  out_reg_wr,
  output logic [REG_ADDR_W-1:0] out_reg_addr_rd,
  output logic [DATA_W-1:0]     out_reg_data_rd,
  output logic                  out_flush,
  output logic                  stall_req,
  stage_mm_if.master            bus
);

  import stage_mm_pkg::*;

  logic              cpl;
  logic              cpl_load;
  logic [DATA_W-1:0] cpl_data;
  logic              skip;

  mm_bus_if #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bus (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .stall      (stall),
    .flush      (flush),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .alu_res    (alu_res),
    .store_data (store_data),
    .bus        (bus),
    .stall_req  (stall_req),
    .cpl        (cpl),
    .cpl_load   (cpl_load),
    .cpl_data   (cpl_data),
    .skip       (skip)
  );

  // Bubbles while busy keep EX from forwarding a result that does not exist yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_flush       <= 1'b1;
      out_reg_wr      <= 1'b0;
      out_reg_addr_rd <= '0;
      out_reg_data_rd <= '0;
    end else if (cpl) begin
      out_flush       <= flush;
      out_reg_wr      <= reg_wr && !flush;
      out_reg_addr_rd <= reg_addr_rd;
      out_reg_data_rd <= cpl_load ? cpl_data : alu_res;
    end else if (!stall && (stall_req || skip)) begin
      out_flush  <= 1'b1;
      out_reg_wr <= 1'b0;
    end else if (en && !stall) begin
      out_flush       <= flush;
      out_reg_wr      <= reg_wr && !flush;
      out_reg_addr_rd <= reg_addr_rd;
      out_reg_data_rd <= alu_res;
    end
  end

endmodule

// File: tb/tb_stage_mm.sv
// Directed self-checking bench for stage_mm with a hand-driven memory responder.
module tb_stage_mm;

  import stage_mm_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, stall, flush, reg_wr, mem_rd, mem_wr;
  logic [RW-1:0] reg_addr_rd;
  logic [DW-1:0] alu_res, store_data;
  logic          out_reg_wr, out_flush, stall_req;
  logic [RW-1:0] out_reg_addr_rd;
  logic [DW-1:0] out_reg_data_rd;

  int n_checks = 0;
  int n_errors = 0;
  int hi;

  always #5 clk = ~clk;

  stage_mm_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  stage_mm #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .REG_ADDR_W (RW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en              (en),
    .stall           (stall),
    .flush           (flush),
    .reg_wr          (reg_wr),
    .reg_addr_rd     (reg_addr_rd),
    .alu_res         (alu_res),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .store_data      (store_data),
    .out_reg_wr      (out_reg_wr),
    .out_reg_addr_rd (out_reg_addr_rd),
    .out_reg_data_rd (out_reg_data_rd),
    .out_flush       (out_flush),
    .stall_req       (stall_req),
    .bus             (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    en             = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    reg_wr         = 1'b0;
    reg_addr_rd    = '0;
    alu_res        = '0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    store_data     = '0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic wen,
                        input logic [RW-1:0] rd_addr, input logic [DW-1:0] alu,
                        input logic [DW-1:0] sd);
    mem_rd      = rd;
    mem_wr      = wr;
    reg_wr      = wen;
    reg_addr_rd = rd_addr;
    alu_res     = alu;
    store_data  = sd;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    #12;
    check("rst_flush", 64'(out_flush), 64'd1);
    check("rst_wr",    64'(out_reg_wr), 64'd0);
    check("rst_addr",  64'(out_reg_addr_rd), 64'd0);
    check("rst_data",  64'(out_reg_data_rd), 64'd0);
    check("rst_req",   64'(bus.mem_req), 64'd0);
    rst_n = 1'b1;

    // ALU passthrough
    set_op(1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h0);
    #1;
    check("alu_req",  64'(bus.mem_req), 64'd0);
    check("alu_sreq", 64'(stall_req), 64'd0);
    cyc();
    check("alu_wr",    64'(out_reg_wr), 64'd1);
    check("alu_flush", 64'(out_flush), 64'd0);
    check("alu_addr",  64'(out_reg_addr_rd), 64'd5);
    check("alu_data",  64'(out_reg_data_rd), 64'h1234);

    // Load: gnt in cycle 2, rvalid in cycle 5
    set_op(1'b1, 1'b0, 1'b1, 5'd7, 32'h100, 32'h0);
    hi = 0;
    for (int c = 0; c < 6; c++) begin
      bus.mem_gnt    = (c == 2);
      bus.mem_rvalid = (c == 5);
      bus.mem_rdata  = (c == 5) ? 32'hDEADBEEF : 32'h0;
      #1;
      check("ld_req", 64'(bus.mem_req), 64'(c <= 2));
      if (c <= 2) check("ld_maddr", 64'(bus.mem_addr), 64'h100);
      if (c <= 2) check("ld_we", 64'(bus.mem_we), 64'd0);
      check("ld_sreq", 64'(stall_req), 64'(c < 5));
      if (c >= 1) check("ld_bubble_flush", 64'(out_flush), 64'd1);
      if (c >= 1) check("ld_bubble_wr", 64'(out_reg_wr), 64'd0);
      if (stall_req) hi++;
      cyc();
    end
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    check("ld_sreq_cycles", 64'(hi), 64'd5);
    check("ld_data",  64'(out_reg_data_rd), 64'hDEADBEEF);
    check("ld_addr",  64'(out_reg_addr_rd), 64'd7);
    check("ld_wr",    64'(out_reg_wr), 64'd1);
    check("ld_flush", 64'(out_flush), 64'd0);

    // Store with immediate grant
    set_op(1'b0, 1'b1, 1'b0, 5'd3, 32'h200, 32'hA5A5A5A5);
    bus.mem_gnt = 1'b1;
    #1;
    check("st_req",   64'(bus.mem_req), 64'd1);
    check("st_we",    64'(bus.mem_we), 64'd1);
    check("st_maddr", 64'(bus.mem_addr), 64'h200);
    check("st_wdata", 64'(bus.mem_wdata), 64'hA5A5A5A5);
    check("st_sreq",  64'(stall_req), 64'd0);
    cyc();
    bus.mem_gnt = 1'b0;
    check("st_wr",    64'(out_reg_wr), 64'd0);
    check("st_flush", 64'(out_flush), 64'd0);

    // Store with one wait cycle: request must hold the captured address/data
    set_op(1'b0, 1'b1, 1'b0, 5'd4, 32'h600, 32'h0F0F0F0F);
    #1;
    check("stw_sreq0", 64'(stall_req), 64'd1);
    check("stw_req0",  64'(bus.mem_req), 64'd1);
    cyc();
    alu_res     = 32'h777;
    store_data  = 32'h0;
    bus.mem_gnt = 1'b1;
    #1;
    check("stw_req1",   64'(bus.mem_req), 64'd1);
    check("stw_maddr",  64'(bus.mem_addr), 64'h600);
    check("stw_wdata",  64'(bus.mem_wdata), 64'h0F0F0F0F);
    check("stw_we",     64'(bus.mem_we), 64'd1);
    check("stw_sreq1",  64'(stall_req), 64'd0);
    cyc();
    bus.mem_gnt = 1'b0;
    check("stw_flush", 64'(out_flush), 64'd0);
    check("stw_wr",    64'(out_reg_wr), 64'd0);

    // Load completing under external stall parks in DONE
    drive_idle();
    set_op(1'b1, 1'b0, 1'b1, 5'd9, 32'h300, 32'h0);
    bus.mem_gnt = 1'b1;
    #1;
    check("lds_sreq0", 64'(stall_req), 64'd1);
    cyc();
    bus.mem_gnt    = 1'b0;
    stall          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    #1;
    check("lds_fin_sreq", 64'(stall_req), 64'd0);
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lds_state",  64'(dut.u_bus.state_q), 64'(MM_DONE));
      check("lds_sreq",   64'(stall_req), 64'd1);
      check("lds_flush",  64'(out_flush), 64'd1);
      check("lds_wr",     64'(out_reg_wr), 64'd0);
      check("lds_early",  64'(out_reg_data_rd == 32'hCAFEF00D), 64'd0);
      cyc();
    end
    stall = 1'b0;
    #1;
    check("lds_drop_sreq", 64'(stall_req), 64'd1);
    check("lds_drop_flush", 64'(out_flush), 64'd1);
    cyc();
    check("lds_data",  64'(out_reg_data_rd), 64'hCAFEF00D);
    check("lds_addr",  64'(out_reg_addr_rd), 64'd9);
    check("lds_wr1",   64'(out_reg_wr), 64'd1);
    check("lds_flush1", 64'(out_flush), 64'd0);
    #1;
    check("lds_noreissue", 64'(bus.mem_req), 64'd0);
    cyc();
    drive_idle();

    // Bubble carrying a load flag
    set_op(1'b1, 1'b0, 1'b1, 5'd6, 32'h123, 32'h0);
    flush = 1'b1;
    #1;
    check("bub_req",  64'(bus.mem_req), 64'd0);
    check("bub_sreq", 64'(stall_req), 64'd0);
    cyc();
    check("bub_flush", 64'(out_flush), 64'd1);
    check("bub_wr",    64'(out_reg_wr), 64'd0);
    drive_idle();

    // Reset while waiting for read data, then a stray rvalid
    set_op(1'b1, 1'b0, 1'b1, 5'd10, 32'h400, 32'h0);
    bus.mem_gnt = 1'b1;
    #1;
    cyc();
    bus.mem_gnt = 1'b0;
    #1;
    check("rw_req_wait", 64'(bus.mem_req), 64'd0);
    check("rw_sreq_wait", 64'(stall_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rw_req",   64'(bus.mem_req), 64'd0);
    check("rw_flush", 64'(out_flush), 64'd1);
    check("rw_wr",    64'(out_reg_wr), 64'd0);
    check("rw_addr",  64'(out_reg_addr_rd), 64'd0);
    check("rw_data",  64'(out_reg_data_rd), 64'd0);
    cyc();
    rst_n = 1'b1;
    drive_idle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hBAD0BAD0;
    #1;
    check("stray_sreq", 64'(stall_req), 64'd0);
    check("stray_req",  64'(bus.mem_req), 64'd0);
    cyc();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    check("stray_data", 64'(out_reg_data_rd), 64'd0);
    check("stray_wr",   64'(out_reg_wr), 64'd0);

    set_op(1'b1, 1'b0, 1'b1, 5'd11, 32'h500, 32'h0);
    bus.mem_gnt = 1'b1;
    #1;
    check("ld2_req",  64'(bus.mem_req), 64'd1);
    check("ld2_sreq0", 64'(stall_req), 64'd1);
    cyc();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h55AA1234;
    #1;
    check("ld2_sreq1", 64'(stall_req), 64'd0);
    cyc();
    drive_idle();
    check("ld2_data", 64'(out_reg_data_rd), 64'h55AA1234);
    check("ld2_addr", 64'(out_reg_addr_rd), 64'd11);
    check("ld2_wr",   64'(out_reg_wr), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
